// File: rtl/booth_seq_multiplier.sv
// Radix-2 sequential signed Booth multiplier driven by an external Booth recode unit (optional BoothOp check: BOOTH_OPCHECK_EN).
// Latency: start sampled at edge k -> done pulse in the cycle after edge k+WIDTH+1; one result per WIDTH+2 cycles.
// Backpressure: none; start is ignored while busy, product holds until the next result is written.
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [1:0]           BoothOp,
    output logic                 q1,
    output logic                 q0,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 op_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [WIDTH:0]   m;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a_sum;

    // Booth unit sees only registered bits, so there is no loop through BoothOp.
    assign q1 = q[0];
    assign q0 = qm1;

    // One extra accumulator bit keeps -2^(WIDTH-1) multiplicands exact.
    always_comb begin
        a_sum = a;
        case (BoothOp)
            2'b01:   a_sum = a + m;
            2'b10:   a_sum = a - m;
            default: a_sum = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a       <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            m       <= '0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a     <= '0;
                        q     <= multiplier;
                        qm1   <= 1'b0;
                        m     <= {multiplicand[WIDTH-1], multiplicand};
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a     <= {a_sum[WIDTH], a_sum[WIDTH:1]};
                    q     <= {a_sum[0], q[WIDTH-1:1]};
                    qm1   <= q[0];
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    product <= {a[WIDTH-1:0], q};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BOOTH_OPCHECK_EN
    logic [1:0] exp_op;

    always_comb begin
        exp_op = 2'b00;
        case ({q1, q0})
            2'b01:   exp_op = 2'b01;
            2'b10:   exp_op = 2'b10;
            default: exp_op = 2'b00;
        endcase
    end

    // Sticky until reset; the datapath still obeys whatever BoothOp arrived.
    always_ff @(posedge clk) begin
        if (!rst_n)
            op_err <= 1'b0;
        else if (state == S_RUN && BoothOp != exp_op)
            op_err <= 1'b1;
    end
`else
    assign op_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier (WIDTH=32) with a behavioural Booth recode unit.
module tb_booth_seq_multiplier;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [1:0]     booth_op;
    logic           q1, q0, busy, done, op_err;
    logic [2*W-1:0] product;
    logic           force_bad = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             at_cyc;
        bit             chk;
    } exp_t;

    exp_t sb[$];

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .BoothOp      (booth_op),
        .q1           (q1),
        .q0           (q0),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .op_err       (op_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Booth control unit, with an override to inject an illegal 11 code.
    always_comb begin
        booth_op = 2'b00;
        if (force_bad)
            booth_op = 2'b11;
        else if ({q1, q0} == 2'b01)
            booth_op = 2'b01;
        else if ({q1, q0} == 2'b10)
            booth_op = 2'b10;
    end

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got product %h expected no done (cycle %0d)", product, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.at_cyc));
                if (e.chk)
                    check("product", product, e.prod);
            end
        end
    end

    // Call #1 after an edge with the DUT idle; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] mc, input logic [W-1:0] mp,
                         input logic [2*W-1:0] exp, input bit push, input bit chk);
        start = 1'b1;
        multiplicand = mc;
        multiplier = mp;
        @(posedge clk);
        #1;
        start = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        if (push)
            sb.push_back('{exp, cyc + W + 1, chk});
    endtask

    task automatic run(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic [2*W-1:0] exp);
        issue(mc, mp, exp, 1'b1, 1'b1);
        repeat (W + 1) @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx, sy;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        return sx * sy;
    endfunction

    logic exp_err;

    initial begin
        `ifdef BOOTH_OPCHECK_EN
        exp_err = 1'b1;
        `else
        exp_err = 1'b0;
        `endif

        repeat (2) @(posedge clk);
        #1;
        check("rst_product", product, 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_op_err", 64'(op_err), 64'h0);
        check("rst_q1q0", 64'({q1, q0}), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        check("busy_after_done", 64'(busy), 64'h0);
        run(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run(32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        run(32'd0, 32'h8000_0000, 64'h0);
        run(32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001);

        // Second start during RUN must be ignored; next start right after done.
        issue(32'd5, 32'd6, 64'd30, 1'b1, 1'b1);
        check("busy_in_run", 64'(busy), 64'h1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        multiplicand = 32'd9;
        multiplier = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (W + 1 - 10) @(posedge clk);
        #1;
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

        // Reset in RUN cycle 15 aborts without a done pulse.
        issue(32'd123, 32'd456, 64'h0, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_product", product, 64'h0);
        repeat (W + 4) @(posedge clk);
        #1;
        run(32'd3, 32'd4, 64'd12);
        check("op_err_clean", 64'(op_err), 64'h0);

        // Illegal code injected on an iteration whose real code is 00, so product stays 15.
        issue(32'd3, 32'd5, 64'd15, 1'b1, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        force_bad = 1'b1;
        @(posedge clk);
        #1;
        force_bad = 1'b0;
        repeat (W + 1 - 10) @(posedge clk);
        #1;
        check("op_err_set", 64'(op_err), 64'(exp_err));
        repeat (5) @(posedge clk);
        #1;
        check("op_err_sticky", 64'(op_err), 64'(exp_err));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("op_err_cleared", 64'(op_err), 64'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] x, y;
            x = $urandom;
            y = $urandom;
            run(x, y, smul(x, y));
        end
        check("op_err_random", 64'(op_err), 64'h0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_seq_multiplier.md
BOOTH_SEQ_MULTIPLIER -- requirements
Module: booth_seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal range is 4..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port multiplicand, input, WIDTH bits: signed two's-complement M, captured on accepted start.
REQ-006 The block SHALL have port multiplier, input, WIDTH bits: signed two's-complement Q, captured on accepted start.
REQ-007 The block SHALL have port BoothOp, input, 2 bits: recode decision returned by the external Booth control unit (01 = add M, 10 = subtract M, 00/11 = none).
REQ-008 The block SHALL have port q1, output, 1 bit: the current Q[0] bit, driven to the Booth control unit.
REQ-009 The block SHALL have port q0, output, 1 bit: the current Q[-1] bit, driven to the Booth control unit.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse when product is valid.
REQ-012 The block SHALL have port product, output, 2*WIDTH bits: the signed result, held until the next accepted start.
REQ-013 The block SHALL have port op_err, output, 1 bit: a sticky BoothOp protocol error flag (see Configuration).

Function
REQ-014 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 The FSM SHALL transition IDLE->RUN on start=1, and SHALL remain in RUN for exactly WIDTH cycles.
REQ-016 The FSM SHALL transition RUN->DONE after the WIDTH-th iteration, and DONE->IDLE unconditionally after one cycle.
REQ-017 On an accepted start the block SHALL load: A=0 (WIDTH+1 bits), Q=multiplier, Q[-1]=0, M=multiplicand sign-extended to WIDTH+1 bits, count=WIDTH.
REQ-018 q1 and q0 SHALL be driven directly from the registers Q[0] and Q[-1], with no combinational path from BoothOp.
REQ-019 In each RUN cycle, the block SHALL compute A' = A+M if BoothOp=01, A' = A-M if BoothOp=10, and A' = A otherwise, all in WIDTH+1-bit arithmetic.
REQ-020 In each RUN cycle, the block SHALL then arithmetic-shift {A',Q,Q[-1]} right by one and decrement count.
REQ-021 Using WIDTH+1 bits for A SHALL give exact results for all operand pairs, including multiplicand = -2^(WIDTH-1).
REQ-022 In DONE the block SHALL set product = {A[WIDTH-1:0], Q} and assert done=1.
REQ-023 Latency SHALL be as follows: with start sampled at rising edge k, done SHALL be high during the cycle following edge k+WIDTH+1.
REQ-024 The block SHALL accept a new start in the cycle after done, giving a throughput of one result per WIDTH+2 cycles.
REQ-025 start SHALL be ignored while busy=1, and the operand inputs SHALL then be don't-care.
REQ-026 While busy=0, q1/q0 SHALL hold their last values and BoothOp SHALL be ignored.
REQ-027 The operand zero, or a WIDTH=4 corner case, SHALL not change the cycle count; there is no early termination.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL set: state=IDLE, A=0, Q=0, Q[-1]=0, M=0, count=0, product=0, done=0, busy=0, op_err=0, q1=0, q0=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation at that edge: no done pulse, and product is cleared to 0.
REQ-030 If start and rst_n=0 occur at the same edge, reset SHALL win and start SHALL be lost.

Configuration
REQ-031 With macro BOOTH_OPCHECK_EN defined, in each RUN cycle the block SHALL compare BoothOp against the expected code ({q1,q0}=01 -> 01, 10 -> 10, otherwise 00).
REQ-032 With BOOTH_OPCHECK_EN defined, any mismatch SHALL set op_err=1, which stays set until reset, while the computation continues using the received BoothOp.
REQ-033 With BOOTH_OPCHECK_EN undefined, op_err SHALL be tied to 0 and no checking logic SHALL be present.

Verification
REQ-034 The bench SHALL cover, with WIDTH=32: start with M=7, Q=-3 -> done exactly 34 cycles after start, product=-21 (0xFFFFFFFF_FFFFFFEB).
REQ-035 The bench SHALL cover: M=Q=0x80000000 -> product=0x40000000_00000000; M=0x80000000, Q=1 -> product=0xFFFFFFFF_80000000.
REQ-036 The bench SHALL cover: start with M=5, Q=6, then pulse start again with M=9, Q=9 at cycle 10 -> ignored; a single done with product=30; a new start accepted right after done.
REQ-037 The bench SHALL cover: rst_n low for one cycle at RUN cycle 15 -> busy=0, no done, product=0; a subsequent 3*4 -> 12.
REQ-038 The bench SHALL cover, with BOOTH_OPCHECK_EN: the stub forces BoothOp=11 in one RUN cycle -> op_err=1 and stays 1 until rst_n; without the macro -> op_err stays 0.
REQ-039 The bench SHALL cover: 1000 random signed operand pairs driven through the real Booth control unit -> every product equals the reference signed multiply.
